// File: rtl/mos6502_fetch_if.sv
// Memory read bus between the 6502 fetch unit and program memory.
// Signal names keep the fetch unit's point of view (_o driven by it, _i driven by memory).
interface mos6502_fetch_if;
  logic [15:0] mem_addr_o;
  logic        mem_rd_o;
  logic [7:0]  mem_data_i;
  logic        mem_ready_i;

  modport master (
    output mem_addr_o,
    output mem_rd_o,
    input  mem_data_i,
    input  mem_ready_i
  );

  modport slave (
    input  mem_addr_o,
    input  mem_rd_o,
    output mem_data_i,
    output mem_ready_i
  );
endinterface

// File: rtl/mos6502_fetch.sv
// 6502 instruction fetch unit: reads the opcode, lets the decoder classify it,
// then reads 0-2 operand bytes and pulses insn_valid_o once the instruction is complete.
module mos6502_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   fetch_start_i,
  input  logic                   pc_load_i,
  input  logic [15:0]            pc_load_value_i,
  mos6502_fetch_if.master        mem_bus,
  output logic [7:0]             instruction_o,
  input  logic [10:0]            addr_mode_i,
  output logic [7:0]             operand_lo_o,
  output logic [7:0]             operand_hi_o,
  output logic [15:0]            pc_o,
  output logic                   insn_valid_o,
  output logic                   busy_o
);

  // One-hot addressing-mode bit positions as delivered by the decoder.
  localparam int unsigned M_XIND = 9;
  localparam int unsigned M_ABSX = 8;
  localparam int unsigned M_ABSY = 7;
  localparam int unsigned M_ABS  = 6;
  localparam int unsigned M_HASH = 5;
  localparam int unsigned M_INDY = 4;
  localparam int unsigned M_IND  = 3;
  localparam int unsigned M_REL  = 2;
  localparam int unsigned M_ZPGX = 1;
  localparam int unsigned M_ZPG  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPCODE,
    S_DECODE,
    S_OPER_LO,
    S_OPER_HI,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pc_inc;
  logic [7:0]  insn_q, insn_d;
  logic [7:0]  op_lo_q, op_lo_d;
  logic [7:0]  op_hi_q, op_hi_d;
  logic        two_q, two_d;
  logic        valid_q;
  logic        busy_q;
  logic        rd_q;
  logic        need_two;
  logic        need_one;

  assign pc_inc = pc_q + 16'd1;

  assign need_two = addr_mode_i[M_ABS] | addr_mode_i[M_ABSX] |
                    addr_mode_i[M_ABSY] | addr_mode_i[M_IND];
  assign need_one = addr_mode_i[M_HASH] | addr_mode_i[M_ZPG] | addr_mode_i[M_ZPGX] |
                    addr_mode_i[M_XIND] | addr_mode_i[M_INDY] | addr_mode_i[M_REL];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    insn_d  = insn_q;
    op_lo_d = op_lo_q;
    op_hi_d = op_hi_q;
    two_d   = two_q;
    case (state_q)
      S_IDLE: begin
        if (pc_load_i)     pc_d    = pc_load_value_i;
        if (fetch_start_i) state_d = S_OPCODE;
      end
      S_OPCODE: begin
        if (mem_bus.mem_ready_i) begin
          insn_d  = mem_bus.mem_data_i;
          pc_d    = pc_inc;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        two_d = need_two;
        if (need_two) begin
          state_d = S_OPER_LO;
        end else if (need_one) begin
          op_hi_d = 8'h00;
          state_d = S_OPER_LO;
        end else begin
          op_lo_d = 8'h00;
          op_hi_d = 8'h00;
          state_d = S_DONE;
        end
      end
      S_OPER_LO: begin
        if (mem_bus.mem_ready_i) begin
          op_lo_d = mem_bus.mem_data_i;
          pc_d    = pc_inc;
          state_d = two_q ? S_OPER_HI : S_DONE;
        end
      end
      S_OPER_HI: begin
        if (mem_bus.mem_ready_i) begin
          op_hi_d = mem_bus.mem_data_i;
          pc_d    = pc_inc;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      insn_q  <= 8'hEA;
      op_lo_q <= 8'h00;
      op_hi_q <= 8'h00;
      two_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      op_lo_q <= op_lo_d;
      op_hi_q <= op_hi_d;
      two_q   <= two_d;
      valid_q <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
      rd_q    <= (state_d == S_OPCODE) || (state_d == S_OPER_LO) || (state_d == S_OPER_HI);
    end
  end

  assign mem_bus.mem_addr_o = pc_q;
  assign mem_bus.mem_rd_o   = rd_q;
  assign instruction_o      = insn_q;
  assign operand_lo_o       = op_lo_q;
  assign operand_hi_o       = op_hi_q;
  assign pc_o               = pc_q;
  assign insn_valid_o       = valid_q;
  assign busy_o             = busy_q;

endmodule

// File: doc/mos6502_fetch.md
MOS6502_FETCH -- requirements
Module: mos6502_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the program counter value after reset.
REQ-002 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit, the reset; asynchronous and active-low.
REQ-004 SHALL have port fetch_start_i, input, 1 bit, a request from the core to fetch the next instruction.
REQ-005 SHALL have port pc_load_i, input, 1 bit, a PC load strobe.
REQ-006 SHALL have port pc_load_value_i, input, 16 bits, the PC value to load.
REQ-007 SHALL have port mem_addr_o, output, 16 bits, the memory read address.
REQ-008 SHALL have port mem_rd_o, output, 1 bit, the memory read request.
REQ-009 SHALL have port mem_data_i, input, 8 bits, the memory read data.
REQ-010 SHALL have port mem_ready_i, input, 1 bit, which marks mem_data_i valid this cycle; low inserts a wait state.
REQ-011 SHALL have port instruction_o, output, 8 bits, the latched opcode; it drives the decoder instruction_i.
REQ-012 SHALL have port addr_mode_i, input, 11 bits, the one-hot addressing mode from the decoder.
- Bit order [10:0]: A, Xind, absX, absY, abs, hash, indY, ind, rel, zpgX, zpg.
REQ-013 SHALL have port operand_lo_o, input-side byte 1, output, 8 bits, the first operand byte.
REQ-014 SHALL have port operand_hi_o, output, 8 bits, the second operand byte.
REQ-015 SHALL have port pc_o, output, 16 bits, the current program counter.
REQ-016 SHALL have port insn_valid_o, output, 1 bit, a one-cycle pulse when the opcode and operands are complete.
REQ-017 SHALL have port busy_o, output, 1 bit, high in every state except IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, OPCODE, DECODE, OPER_LO, OPER_HI and DONE.
REQ-019 In IDLE with fetch_start_i=1, the FSM SHALL go to OPCODE.
REQ-020 In IDLE with pc_load_i=1, pc SHALL take pc_load_value_i.
- If fetch_start_i=1 in the same cycle, the following OPCODE fetch uses the loaded value.
REQ-021 Outside IDLE, pc_load_i and fetch_start_i SHALL be ignored.
REQ-022 In OPCODE, OPER_LO and OPER_HI, the block SHALL drive mem_rd_o=1 and mem_addr_o=pc.
- In all other states, mem_rd_o=0.
- mem_addr_o holds pc in all states.
REQ-023 In OPCODE with mem_ready_i=1, the block SHALL:
- latch mem_data_i into instruction_o;
- increment pc;
- go to DECODE.
- With mem_ready_i=0, it stays in OPCODE with pc unchanged.
REQ-024 DECODE SHALL last exactly one cycle and sample addr_mode_i while instruction_o is stable.
- Operand count is 2 if any of abs, absX, absY or ind is set.
- Otherwise it is 1 if any of hash, zpg, zpgX, Xind, indY or rel is set.
- Otherwise it is 0 (A or implied).
REQ-025 If the operand count is 0, DECODE SHALL go to DONE; otherwise it SHALL go to OPER_LO.
REQ-026 In OPER_LO with mem_ready_i=1, the block SHALL:
- latch mem_data_i into operand_lo_o;
- increment pc;
- go to OPER_HI if the count is 2, else to DONE.
REQ-027 In OPER_HI with mem_ready_i=1, the block SHALL:
- latch mem_data_i into operand_hi_o;
- increment pc;
- go to DONE.
REQ-028 Operand bytes that are not fetched SHALL be cleared to 8'h00 when DECODE is taken.
REQ-029 DONE SHALL assert insn_valid_o for exactly one cycle and then return to IDLE.
REQ-030 instruction_o, operand_lo_o and operand_hi_o SHALL hold their values until the next OPCODE or DECODE update.
REQ-031 The pc increment SHALL be modulo 2^16 (16'hFFFF+1 = 16'h0000), including mid-instruction.
REQ-032 Minimum latency from fetch_start_i to the insn_valid_o pulse, with mem_ready_i tied high, SHALL be:
- 3 cycles for 0 operand bytes;
- 4 cycles for 1 operand byte;
- 5 cycles for 2 operand bytes.
- Each mem_ready_i=0 cycle adds one cycle.

Reset
REQ-033 On rst_ni=0, the block SHALL immediately, without waiting for a clock edge, set:
- state = IDLE;
- pc = RESET_PC;
- instruction_o = 8'hEA;
- operand_lo_o and operand_hi_o = 8'h00;
- insn_valid_o, busy_o and mem_rd_o = 0.
REQ-034 A reset during any state SHALL abort the fetch with no insn_valid_o pulse.
- Operation resumes from IDLE on the first clock edge after rst_ni rises.

Verification
REQ-035 SHALL cover load then fetch of a 0-operand instruction:
- Stimulus: pc_load 16'h0200; memory[0200]=8'h0A (ASL A); addr_mode=A; ready high.
- Response: instruction_o=8'h0A; insn_valid_o 3 cycles after start; pc=16'h0201.
REQ-036 SHALL cover a 2-operand instruction:
- Stimulus: memory 8'h4C, 8'h34, 8'h12 at pc=16'h0300; addr_mode=abs.
- Response: operand_lo_o=8'h34; operand_hi_o=8'h12; pc=16'h0303; insn_valid_o at cycle 5.
REQ-037 SHALL cover a wait state:
- Stimulus: an immediate instruction (8'hA9, 8'h55) with mem_ready_i low for 2 cycles during OPER_LO.
- Response: mem_rd_o and mem_addr_o held; operand_lo_o=8'h55; insn_valid_o at cycle 6.
REQ-038 SHALL cover PC wrap:
- Stimulus: pc=16'hFFFF; opcode 8'hA5 (zpg) at FFFF; operand at 0000.
- Response: operand fetch address = 16'h0000; final pc=16'h0001.
REQ-039 SHALL cover reset mid-fetch:
- Stimulus: rst_ni dropped in OPER_HI.
- Response: with no clock edge, pc=RESET_PC, instruction_o=8'hEA, busy_o=0, no insn_valid_o pulse.
REQ-040 SHALL cover ignored strobes:
- Stimulus: pc_load_i and fetch_start_i asserted while in OPCODE.
- Response: pc is unchanged by the load and only one instruction completes.
